// File: rtl/codec_cfg_pkg.sv
// rtl/codec_cfg_pkg.sv - shared WM8731 register map, script tables and FSM encoding
package codec_cfg_pkg;

  localparam logic [6:0] REG_LINVOL  = 7'h00;
  localparam logic [6:0] REG_RINVOL  = 7'h01;
  localparam logic [6:0] REG_ANAPATH = 7'h04;
  localparam logic [6:0] REG_DIGPATH = 7'h05;
  localparam logic [6:0] REG_PWRDOWN = 7'h06;
  localparam logic [6:0] REG_IFACE   = 7'h07;
  localparam logic [6:0] REG_SRATE   = 7'h08;
  localparam logic [6:0] REG_ACTIVE  = 7'h09;
  localparam logic [6:0] REG_RESET   = 7'h0F;

  typedef enum logic [1:0] {
    SCR_INIT     = 2'd0,
    SCR_AUDIOOFF = 2'd1,
    SCR_AUDIOON  = 2'd2,
    SCR_LOOPBACK = 2'd3
  } script_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP
  } state_e;

  function automatic logic [15:0] cfg_word(input logic [6:0] addr, input logic [8:0] data);
    return {addr, data};
  endfunction

  function automatic logic [3:0] script_start(input script_e s);
    case (s)
      SCR_INIT:     return 4'd0;
      SCR_AUDIOOFF: return 4'd9;
      SCR_AUDIOON:  return 4'd10;
      default:      return 4'd12;
    endcase
  endfunction

  function automatic logic [3:0] script_len(input script_e s);
    case (s)
      SCR_INIT:     return 4'd9;
      SCR_AUDIOOFF: return 4'd1;
      SCR_AUDIOON:  return 4'd2;
      default:      return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/codec_cfg_rom.sv
// rtl/codec_cfg_rom.sv - combinational 13-entry table of codec register writes
module codec_cfg_rom
  import codec_cfg_pkg::*;
(
  input  logic [3:0]  i_index,
  output logic [15:0] o_word
);

  always_comb begin
    o_word = 16'h0000;
    case (i_index)
      4'd0:    o_word = cfg_word(REG_RESET,   9'h000);
      4'd1:    o_word = cfg_word(REG_PWRDOWN, 9'h010);
      4'd2:    o_word = cfg_word(REG_LINVOL,  9'h017);
      4'd3:    o_word = cfg_word(REG_RINVOL,  9'h017);
      4'd4:    o_word = cfg_word(REG_ANAPATH, 9'h012);
      4'd5:    o_word = cfg_word(REG_DIGPATH, 9'h000);
      4'd6:    o_word = cfg_word(REG_IFACE,   9'h002);
      4'd7:    o_word = cfg_word(REG_SRATE,   9'h000);
      4'd8:    o_word = cfg_word(REG_ACTIVE,  9'h001);
      4'd9:    o_word = cfg_word(REG_PWRDOWN, 9'h0FF);
      4'd10:   o_word = cfg_word(REG_PWRDOWN, 9'h000);
      4'd11:   o_word = cfg_word(REG_ANAPATH, 9'h012);
      4'd12:   o_word = cfg_word(REG_ANAPATH, 9'h00A);
      default: o_word = 16'h0000;
    endcase
  end

endmodule

// File: rtl/codec_cfg_sequencer.sv
// rtl/codec_cfg_sequencer.sv - runs codec init/command scripts into the I2C byte-writer
module codec_cfg_sequencer
  import codec_cfg_pkg::*;
#(
  parameter int GAP_CYC     = 64,
  parameter int TIMEOUT_CYC = 65536,
  parameter int MAX_RETRY   = 3
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_loopback_req,
  input  logic        i_audioon_req,
  input  logic        i_audiooff_req,
  output logic        o_wr_valid,
  output logic [15:0] o_wr_word,
  input  logic        i_wr_ready,
  input  logic        i_wr_done,
  input  logic        i_wr_nack,
  output logic        o_busy,
  output logic        o_script_done,
  output logic        o_error,
  output logic [1:0]  o_active_script
);

  // One counter serves both WAIT and GAP, so it is sized for the larger of the two.
  localparam int CNT_MAX = (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  state_e             r_state;
  state_e             w_next;
  logic [3:0]         r_req_q;
  logic [3:0]         r_pending;
  logic [3:0]         r_idx;
  logic [3:0]         r_last_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic [RTY_W-1:0]   r_retry;
  logic               r_last_ok;
  logic               r_done;
  logic               r_error;
  script_e            r_active;
  logic [3:0]         w_req;
  logic [3:0]         w_edge;
  logic [3:0]         w_clr;
  script_e            w_win;
  logic               w_wait_ok;
  logic               w_wait_fail;
  logic               w_gap_end;
  logic [15:0]        w_rom_word;

  codec_cfg_rom u_rom (
    .i_index (r_idx),
    .o_word  (w_rom_word)
  );

  // Bit positions follow script IDs; INIT has no request input.
  assign w_req  = {i_loopback_req, i_audioon_req, i_audiooff_req, 1'b0};
  assign w_edge = w_req & ~r_req_q;
  assign w_clr  = (r_state == ST_ARB) ? (4'b0001 << w_win) : 4'b0000;

  always_comb begin
    w_win = SCR_LOOPBACK;
    if (r_pending[SCR_INIT])          w_win = SCR_INIT;
    else if (r_pending[SCR_AUDIOOFF]) w_win = SCR_AUDIOOFF;
    else if (r_pending[SCR_AUDIOON])  w_win = SCR_AUDIOON;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_wait_ok   = 1'b0;
    w_wait_fail = 1'b0;
    w_gap_end   = 1'b0;
    case (r_state)
      ST_IDLE:  if (|r_pending) w_next = ST_ARB;
      ST_ARB:   w_next = ST_ISSUE;
      ST_ISSUE: if (i_wr_ready) w_next = ST_WAIT;
      ST_WAIT: begin
        if (i_wr_done && !i_wr_nack) begin
          w_wait_ok = 1'b1;
          w_next    = ST_GAP;
        end else if (i_wr_done || (r_cnt == TMO_LAST)) begin
          w_wait_fail = 1'b1;
          w_next      = (r_retry < RTY_MAX) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_gap_end = 1'b1;
          w_next    = (r_last_ok && (r_idx == r_last_idx)) ? ST_IDLE : ST_ISSUE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_req_q    <= 4'b0000;
      r_pending  <= 4'b0001;
      r_idx      <= 4'd0;
      r_last_idx <= 4'd0;
      r_cnt      <= '0;
      r_retry    <= '0;
      r_last_ok  <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_active   <= SCR_INIT;
    end else begin
      r_req_q   <= w_req;
      r_pending <= (r_pending & ~w_clr) | w_edge;
      r_done    <= 1'b0;
      if (w_next != r_state)  r_cnt <= '0;
      else if (r_cnt != '1)   r_cnt <= r_cnt + CNT_W'(1);
      if (r_state == ST_ARB) begin
        r_active   <= w_win;
        r_idx      <= script_start(w_win);
        r_last_idx <= script_start(w_win) + script_len(w_win) - 4'd1;
        r_retry    <= '0;
        r_last_ok  <= 1'b0;
      end
      if (w_wait_ok) begin
        r_last_ok <= 1'b1;
        r_retry   <= '0;
      end
      if (w_wait_fail) begin
        r_last_ok <= 1'b0;
        if (r_retry < RTY_MAX) r_retry <= r_retry + RTY_W'(1);
        else                   r_error <= 1'b1;
      end
      if (w_gap_end && r_last_ok) begin
        if (r_idx == r_last_idx) begin
          r_done  <= 1'b1;
          r_error <= 1'b0;
        end else begin
          r_idx <= r_idx + 4'd1;
        end
      end
    end
  end

  assign o_wr_valid      = (r_state == ST_ISSUE);
  assign o_wr_word       = (r_state == ST_ISSUE) ? w_rom_word : 16'h0000;
  assign o_busy          = (r_state != ST_IDLE);
  assign o_script_done   = r_done;
  assign o_error         = r_error;
  assign o_active_script = r_active;

endmodule
